// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core among NUM_REQ byte-stream requesters, round-robin with per-packet lock.
// Latency: grant the cycle after valid in IDLE; o_Tx_DV the cycle after a handshake; next ready the cycle after i_Tx_Done (plus GAP_CYCLES).
// Backpressure: only the owner sees ready, and only in SEND; a stalled owner loses the lock after IDLE_TIMEOUT idle SEND clocks.
//
// Ports:
//   i_Clk, i_Rst_n            system clock, async active-low reset
//   i_Req_Valid/Data/Last     per-requester byte stream (requester r uses Data[8r+7:8r])
//   o_Req_Ready               per-requester accept strobe (owner only, SEND only)
//   o_Grant                   one-hot current owner, zero when unowned
//   o_Tx_DV, o_Tx_Byte        one-cycle load pulse and byte to the TX core
//   i_Tx_Done                 end-of-byte pulse from the TX core
//   o_Busy, o_Timeout         not-IDLE flag, one-cycle lock-release-by-timeout pulse
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int IDLE_TIMEOUT = 100000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  // Reset value of the last owner: the highest index, so requester 0 wins first.
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_LOAD,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_owner_q, last_owner_d;
  logic [7:0]           byte_q, byte_d;
  logic                 last_q, last_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [TW-1:0]        to_q, to_d;
  logic                 timeout_q, timeout_d;

  logic                 own_vld;
  logic [7:0]           own_dat;
  logic                 own_last;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic                 resolve;

  assign own_vld  = i_Req_Valid[owner_q];
  assign own_dat  = i_Req_Data[{owner_q, 3'b000} +: 8];
  assign own_last = i_Req_Last[owner_q];

  // Round-robin search starting one past the previous owner, so the
  // requester that just finished (or timed out) is considered last.
  always_comb begin
    logic [IW:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_owner_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!pick_found && i_Req_Valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    byte_d       = byte_q;
    last_d       = last_q;
    gap_d        = gap_q;
    to_d         = '0;
    timeout_d    = 1'b0;
    resolve      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (own_vld) begin
          byte_d  = own_dat;
          last_d  = own_last;
          state_d = S_LOAD;
        end else if (IDLE_TIMEOUT != 0) begin
          // Release when this idle clock brings the count up to IDLE_TIMEOUT.
          if (to_q == TW'(IDLE_TIMEOUT - 1)) begin
            timeout_d    = 1'b1;
            grant_d      = '0;
            last_owner_d = owner_q;
            state_d      = S_IDLE;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
      end
      S_LOAD: begin
        gap_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) begin
          if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      S_GAP: begin
        // i_Tx_Done is deliberately not looked at here.
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          resolve = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    // End of a byte: drop the lock after the last byte of a packet,
    // otherwise go straight back for the owner's next byte.
    if (resolve) begin
      if (last_q) begin
        grant_d      = '0;
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end else begin
        state_d = S_SEND;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      byte_q       <= '0;
      last_q       <= 1'b0;
      gap_q        <= '0;
      to_q         <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      gap_q        <= gap_d;
      to_q         <= to_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_Grant     = grant_q;
  assign o_Req_Ready = (state_q == S_SEND) ? grant_q : '0;
  assign o_Tx_DV     = (state_q == S_LOAD);
  assign o_Tx_Byte   = byte_q;
  assign o_Busy      = (state_q != S_IDLE);
  assign o_Timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid, last;
  logic [31:0] data;
  logic [3:0]  ready, grant;
  logic        tx_dv, tx_done, busy, tmo;
  logic [7:0]  tx_byte;

  logic [3:0]  g_valid, g_last;
  logic [31:0] g_data;
  logic [3:0]  g_ready, g_grant;
  logic        g_dv, g_done, g_busy, g_tmo;
  logic [7:0]  g_byte;

  int checks = 0;
  int errors = 0;

  // Reference state: previous owner index for round-robin, packet tables.
  int          m_last;
  int          len [4];
  logic [7:0]  mb  [4][16];
  logic        ml  [4][16];
  int          expq[$];

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .IDLE_TIMEOUT(20)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_Req_Valid(valid), .i_Req_Data(data), .i_Req_Last(last),
    .o_Req_Ready(ready), .o_Grant(grant),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Done(tx_done),
    .o_Busy(busy), .o_Timeout(tmo)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(5), .IDLE_TIMEOUT(0)) dutg (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_Req_Valid(g_valid), .i_Req_Data(g_data), .i_Req_Last(g_last),
    .o_Req_Ready(g_ready), .o_Grant(g_grant),
    .o_Tx_DV(g_dv), .o_Tx_Byte(g_byte), .i_Tx_Done(g_done),
    .o_Busy(g_busy), .o_Timeout(g_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 0; last = 0; data = 0; tx_done = 0;
    g_valid = 0; g_last = 0; g_data = 0; g_done = 0;
    rst_n = 0;
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    m_last = 3;
  endtask

  // Transaction-level expectation: serve whole packets round-robin among
  // requesters that still have data, starting after the previous owner.
  task automatic build_model();
    int p[4];
    int cur, r;
    bit found;
    for (int i = 0; i < 4; i++) p[i] = 0;
    cur = m_last;
    for (int n = 0; n < 64; n++) begin
      found = 0;
      r = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && p[(cur + k) % 4] < len[(cur + k) % 4]) begin
          found = 1;
          r = (cur + k) % 4;
        end
      end
      if (!found) break;
      for (int b = 0; b < 16; b++) begin
        expq.push_back((int'(ml[r][p[r]]) << 12) | (r << 8) | int'(mb[r][p[r]]));
        p[r]++;
        if (ml[r][p[r]-1]) break;
      end
      cur = r;
    end
    m_last = cur;
  endtask

  task automatic run_traffic(input string name);
    int  rptr[4];
    bit  hs[4];
    int  done_cnt, e;
    bit  exp_rdy, cur_last, fin;
    for (int i = 0; i < 4; i++) begin rptr[i] = 0; hs[i] = 0; end
    done_cnt = -1; exp_rdy = 0; cur_last = 0; fin = 0;
    build_model();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int r = 0; r < 4; r++) begin
        if (hs[r]) rptr[r]++;
        if (rptr[r] < len[r]) begin
          valid[r] = 1'b1;
          data[8*r +: 8] = mb[r][rptr[r]];
          last[r] = ml[r][rptr[r]];
        end else begin
          valid[r] = 1'b0;
          data[8*r +: 8] = 8'h00;
          last[r] = 1'b0;
        end
      end
      tx_done = 0;
      if (done_cnt == 0) begin tx_done = 1; done_cnt = -1; end
      else if (done_cnt > 0) done_cnt--;

      if (exp_rdy) begin
        checks++;
        if (ready !== grant || grant == 4'b0) begin
          errors++;
          $display("FAIL %s back_to_back: ready=%b grant=%b, required ready=grant (nonzero) the cycle after done", name, ready, grant);
        end
        exp_rdy = 0;
      end
      if (tx_done && !cur_last) exp_rdy = 1;

      checks++;
      if ((ready & ~grant) != 4'b0) begin
        errors++;
        $display("FAIL %s ready_owner_only: ready=%b grant=%b", name, ready, grant);
      end

      if (tx_dv) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL %s extra_byte: got %h, required no further byte", name, tx_byte);
        end else begin
          e = expq.pop_front();
          cur_last = e[12];
          if (tx_byte !== e[7:0] || grant !== (4'b0001 << e[11:8])) begin
            errors++;
            $display("FAIL %s byte_order: got byte %h grant %b, required byte %h grant %b",
                     name, tx_byte, grant, e[7:0], 4'b0001 << e[11:8]);
          end
        end
        done_cnt = $urandom_range(0, 4);
      end
      for (int r = 0; r < 4; r++) hs[r] = ready[r] & valid[r];

      if (expq.size() == 0 && done_cnt < 0 && !tx_done && !busy && valid == 4'b0) begin
        fin = 1;
        break;
      end
    end
    checks++;
    if (!fin || grant !== 4'b0) begin
      errors++;
      $display("FAIL %s completion: finished=%0d grant=%b left=%0d, required finished with grant 0000", name, fin, grant, expq.size());
    end
    expq.delete();
    valid = 0; last = 0; data = 0; tx_done = 0;
  endtask

  task automatic clear_tables();
    for (int r = 0; r < 4; r++) begin
      len[r] = 0;
      for (int i = 0; i < 16; i++) begin mb[r][i] = 8'h00; ml[r][i] = 1'b0; end
    end
  endtask

  task automatic test_reset();
    valid = 0; last = 0; data = 0; tx_done = 0;
    g_valid = 0; g_last = 0; g_data = 0; g_done = 0;
    rst_n = 0;
    #3;
    checks++;
    if ({grant, ready, tx_dv, tx_byte, busy, tmo} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b ready=%b dv=%b byte=%h busy=%b tmo=%b, required all 0", grant, ready, tx_dv, tx_byte, busy, tmo);
    end
    do_reset();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0 || g_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b grant=%b g_busy=%b, required 0 0000 0", busy, grant, g_busy);
    end
  endtask

  task automatic test_single();
    valid = 4'b0001; data = 32'h41; last = 4'b0001;
    checks++;
    if (grant !== 4'b0) begin errors++; $display("FAIL single_pre_grant: got %b required 0000", grant); end
    cyc();
    checks++;
    if (grant !== 4'b0001 || ready !== 4'b0001 || tx_dv !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant=%b ready=%b dv=%b, required 0001 0001 0", grant, ready, tx_dv);
    end
    cyc();
    valid = 0; data = 0; last = 0;
    checks++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h41 || ready !== 4'b0) begin
      errors++;
      $display("FAIL single_load: dv=%b byte=%h ready=%b, required 1 41 0000", tx_dv, tx_byte, ready);
    end
    cyc();
    checks++;
    if (tx_dv !== 1'b0 || busy !== 1'b1 || tx_byte !== 8'h41) begin
      errors++;
      $display("FAIL single_wait: dv=%b busy=%b byte=%h, required 0 1 41", tx_dv, busy, tx_byte);
    end
    tx_done = 1;
    cyc();
    tx_done = 0;
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b, required 0000 0", grant, busy);
    end
    m_last = 0;
  endtask

  task automatic test_two_pkts();
    clear_tables();
    len[1] = 2; mb[1][0] = 8'h10; mb[1][1] = 8'h11; ml[1][1] = 1;
    len[2] = 2; mb[2][0] = 8'h20; mb[2][1] = 8'h21; ml[2][1] = 1;
    run_traffic("two_pkts");
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_tables();
    for (int r = 0; r < 4; r++) begin
      len[r] = 2;
      for (int i = 0; i < 2; i++) begin mb[r][i] = 8'(8'h80 + 16*r + i); ml[r][i] = 1; end
    end
    run_traffic("round_robin");
  endtask

  task automatic test_back_to_back();
    for (int round = 0; round < 4; round++) begin
      clear_tables();
      for (int r = 0; r < 4; r++) begin
        len[r] = $urandom_range(0, 6);
        for (int i = 0; i < len[r]; i++) begin
          mb[r][i] = 8'($urandom_range(0, 255));
          ml[r][i] = (i == len[r] - 1) || ($urandom_range(0, 2) == 0);
        end
      end
      run_traffic("random");
    end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    valid = 4'b1000; data = 32'h33000000; last = 4'b0000;
    cyc();
    checks++;
    if (grant !== 4'b1000 || ready !== 4'b1000) begin
      errors++;
      $display("FAIL tmo_grant: grant=%b ready=%b, required 1000 1000", grant, ready);
    end
    cyc();
    valid = 4'b0001; data = 32'h00000055; last = 4'b0001;
    checks++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h33) begin
      errors++;
      $display("FAIL tmo_load: dv=%b byte=%h, required 1 33", tx_dv, tx_byte);
    end
    cyc();
    tx_done = 1;
    cyc();
    tx_done = 0;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (tmo) break;
      if (grant !== 4'b1000) break;
      cyc();
      cnt++;
    end
    checks++;
    if (cnt != 20 || tmo !== 1'b1 || grant !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_release: after %0d clocks tmo=%b grant=%b busy=%b, required 20 clocks 1 0000 0", cnt, tmo, grant, busy);
    end
    cyc();
    checks++;
    if (tmo !== 1'b0 || grant !== 4'b0001 || ready !== 4'b0001) begin
      errors++;
      $display("FAIL tmo_next_owner: tmo=%b grant=%b ready=%b, required 0 0001 0001", tmo, grant, ready);
    end
    cyc();
    valid = 0; data = 0; last = 0;
    checks++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h55) begin
      errors++;
      $display("FAIL tmo_next_byte: dv=%b byte=%h, required 1 55", tx_dv, tx_byte);
    end
    cyc();
    tx_done = 1;
    cyc();
    tx_done = 0;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      errors++;
      $display("FAIL tmo_done: busy=%b grant=%b, required 0 0000", busy, grant);
    end
    m_last = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 4'b1000; data = 32'h77000000; last = 4'b1000;
    cyc();
    cyc();
    valid = 0; data = 0; last = 0;
    cyc();
    checks++;
    if (busy !== 1'b1 || grant !== 4'b1000 || tx_byte !== 8'h77) begin
      errors++;
      $display("FAIL mid_wait: busy=%b grant=%b byte=%h, required 1 1000 77", busy, grant, tx_byte);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({grant, ready, tx_dv, tx_byte, busy, tmo} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: grant=%b ready=%b dv=%b byte=%h busy=%b tmo=%b, required all 0", grant, ready, tx_dv, tx_byte, busy, tmo);
    end
    valid = 4'b1001; data = 32'h77000011; last = 4'b1001;
    cyc();
    rst_n = 1;
    cyc();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first_grant: got %b, required 0001", grant);
    end
    do_reset();
  endtask

  task automatic test_gap();
    int k, d2;
    g_valid = 4'b0010; g_data = 32'h0000A000; g_last = 4'b0000;
    for (k = 0; k < 10; k++) begin
      cyc();
      if (g_ready[1]) break;
    end
    cyc();
    g_data = 32'h0000A100; g_last = 4'b0010;
    checks++;
    if (g_dv !== 1'b1 || g_byte !== 8'hA0) begin
      errors++;
      $display("FAIL gap_first_byte: dv=%b byte=%h, required 1 a0", g_dv, g_byte);
    end
    cyc();
    g_done = 1;
    cyc();
    for (k = 1; k < 20; k++) begin
      if (g_ready[1]) break;
      g_done = (k == 2 || k == 4);
      cyc();
    end
    g_done = 0;
    checks++;
    if (k - 1 != 5 || g_ready !== 4'b0010) begin
      errors++;
      $display("FAIL gap_length: ready after %0d gap clocks ready=%b, required 5 clocks 0010", k - 1, g_ready);
    end
    cyc();
    g_valid = 0; g_data = 0; g_last = 0;
    checks++;
    if (g_dv !== 1'b1 || g_byte !== 8'hA1) begin
      errors++;
      $display("FAIL gap_second_byte: dv=%b byte=%h, required 1 a1", g_dv, g_byte);
    end
    cyc();
    g_done = 1;
    cyc();
    g_done = 0;
    d2 = 1;
    repeat (4) begin cyc(); d2++; end
    checks++;
    if (g_busy !== 1'b1 || g_grant !== 4'b0010) begin
      errors++;
      $display("FAIL gap_hold: at gap clock %0d busy=%b grant=%b, required 1 0010", d2, g_busy, g_grant);
    end
    cyc();
    checks++;
    if (g_busy !== 1'b0 || g_grant !== 4'b0) begin
      errors++;
      $display("FAIL gap_release: busy=%b grant=%b, required 0 0000", g_busy, g_grant);
    end
  endtask

  initial begin
    m_last = 3;
    test_reset();
    test_single();
    test_two_pkts();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NUM_REQ byte-stream requesters (button handler, status reporter, debug echo, etc.).
- Grants the transmitter round-robin with per-packet locking: a granted requester keeps it until it hands over a byte flagged last.
- Feeds one byte at a time to the TX core, waiting for its done pulse each time.
- Enforces an optional inter-byte gap and releases a stalled lock after a timeout.
- Sits between the requester logic and the TX serializer inside top; runs on the 100 MHz system clock.

Parameters:
NUM_REQ, 4, number of requesters; legal 2..8.
GAP_CYCLES, 0, idle clocks inserted after each i_Tx_Done before the next byte may be accepted; 0 = no gap.
IDLE_TIMEOUT, 100000, consecutive clocks in SEND with the granted requester's valid low before the lock is forcibly released; 0 = never release.

Ports:
i_Clk  in  1  system clock, rising edge.
i_Rst_n  in  1  asynchronous active-low reset.
i_Req_Valid  in  NUM_REQ  per-requester byte valid.
i_Req_Data  in  8*NUM_REQ  per-requester byte; requester r uses bits [8r+7:8r].
i_Req_Last  in  NUM_REQ  per-requester last-byte-of-packet flag, qualified by valid.
o_Req_Ready  out  NUM_REQ  per-requester accept strobe.
o_Grant  out  NUM_REQ  one-hot current owner; all zero when unowned.
o_Tx_DV  out  1  one-cycle start pulse to the TX core.
o_Tx_Byte  out  8  byte to the TX core; valid while o_Tx_DV is high, held until the next load.
i_Tx_Done  in  1  one-cycle pulse from the TX core at the end of the stop bit.
o_Busy  out  1  high in every state except IDLE.
o_Timeout  out  1  one-cycle pulse when a lock is released by timeout.

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - State goes to IDLE.
  - o_Grant, o_Req_Ready, o_Tx_DV, o_Tx_Byte, o_Busy and o_Timeout are all 0.
  - The round-robin pointer is set so requester 0 has top priority.
  - Gap and timeout counters clear.
- Reset mid-byte abandons the byte. The TX core has its own reset; the arbiter does not resynchronise to it.
- States: IDLE, SEND, LOAD, WAIT_DONE, GAP.
- IDLE:
  - If any i_Req_Valid is high, pick the first valid requester starting at (last_owner+1) mod NUM_REQ.
  - Register its one-hot into o_Grant and go to SEND. o_Grant is visible the next cycle.
- SEND:
  - o_Req_Ready = o_Grant. This is combinational from registered state; no ready is given to any other requester.
  - Handshake = valid & ready of the owner in the same cycle. On handshake: latch the data byte into o_Tx_Byte, latch the last flag, and go to LOAD.
  - While the owner's valid is low, increment the timeout counter; it clears whenever valid is high.
  - When the counter reaches IDLE_TIMEOUT: pulse o_Timeout, clear o_Grant, set last_owner = owner, go to IDLE.
- LOAD: o_Tx_DV = 1 for exactly this cycle (cycle after the handshake), then go to WAIT_DONE.
- WAIT_DONE:
  - Stay until i_Tx_Done. On done: go to GAP if GAP_CYCLES > 0.
  - Otherwise resolve directly: latched last = 1 → clear o_Grant, update last_owner, go to IDLE; else → SEND.
- GAP: count GAP_CYCLES clocks, then resolve exactly as above.
- i_Tx_Done outside WAIT_DONE is ignored.
- Data contract:
  - A requester holds data and last stable while valid is high and ready is low.
  - Valid and last from non-owners have no effect on the current packet.
- Throughput with GAP_CYCLES = 0 and the owner holding valid: the next handshake occurs the cycle after i_Tx_Done, since the state is SEND on that cycle.
- Fairness: after a packet or timeout from requester k, requester k has lowest priority in the next IDLE arbitration.
- A single-byte packet is a byte with last = 1 on its first handshake.
- A requester raising valid in the same cycle the lock returns to IDLE is considered in the next arbitration.
- Counters are sized with $clog2(param+1). Do not wrap: the timeout counter saturates at IDLE_TIMEOUT.

Test Plan:
- Reset, then requester 0 sends 0x41 with last=1 → o_Grant=0001 one cycle after valid; ready for one cycle; o_Tx_DV one cycle later with o_Tx_Byte=0x41; IDLE after i_Tx_Done; o_Grant=0000.
- Requesters 1 and 2 both raise valid with 2-byte packets 0x10,0x11 and 0x20,0x21 → o_Tx_Byte sequence 0x10,0x11,0x20,0x21; no interleave; o_Grant 0010 then 0100.
- All four requesters hold valid continuously with single-byte packets → grant order 0,1,2,3,0,…; every requester served once per four bytes.
- GAP_CYCLES=5 → exactly 5 clocks between i_Tx_Done and the next ready for the same owner; i_Tx_Done pulses injected during GAP are ignored.
- IDLE_TIMEOUT=20; requester 3 sends one non-last byte and then drops valid → o_Timeout pulses 20 clocks after valid falls; o_Grant clears; pending requester 0 is granted next.
- Assert i_Rst_n low during WAIT_DONE → all outputs 0 immediately; after release, requester 0 is granted first even if requester 3 was the owner.
